// File: rtl/ysyx_mem_arb.sv
// Memory bus arbiter: LSU (store > load) over IFU, with a starvation bound protecting IFU.
// Optional watchdog abort is enabled by defining YSYX_MEM_ARB_TIMEOUT_EN.
module ysyx_mem_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] ifu_araddr,
  input  logic            ifu_arvalid,
  output logic [XLEN-1:0] out_ifu_rdata,
  output logic            out_ifu_rvalid,
  input  logic [XLEN-1:0] lsu_araddr,
  input  logic            lsu_arvalid,
  input  logic [7:0]      lsu_rstrb,
  output logic [XLEN-1:0] out_lsu_rdata,
  output logic            out_lsu_rvalid,
  input  logic [XLEN-1:0] lsu_awaddr,
  input  logic            lsu_awvalid,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic [7:0]      lsu_wstrb,
  output logic            out_lsu_wready,
  output logic [XLEN-1:0] out_bus_araddr,
  output logic            out_bus_arvalid,
  output logic [7:0]      out_bus_rstrb,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_rvalid,
  output logic [XLEN-1:0] out_bus_awaddr,
  output logic            out_bus_awvalid,
  output logic [XLEN-1:0] out_bus_wdata,
  output logic [7:0]      out_bus_wstrb,
  output logic            out_bus_wvalid,
  input  logic            bus_wready,
  output logic            out_bus_err,
  output logic            out_busy
);

  typedef enum logic [2:0] {IDLE, G_IFU, G_LD, G_ST, DRAIN} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t          state, state_nx;
  logic [SW-1:0]   starve_cnt;
  logic            starve_full, gnt_ifu, gnt_ld, gnt_st;
  logic [XLEN-1:0] lat_addr, lat_wdata;
  logic [7:0]      lat_strb;
  logic            lat_wr;
  logic            wd_hit;

  assign starve_full = (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    gnt_ifu = 1'b0;
    gnt_ld  = 1'b0;
    gnt_st  = 1'b0;
    if (state == IDLE) begin
      if (starve_full && ifu_arvalid) gnt_ifu = 1'b1;
      else if (lsu_awvalid)           gnt_st  = 1'b1;
      else if (lsu_arvalid)           gnt_ld  = 1'b1;
      else if (ifu_arvalid)           gnt_ifu = 1'b1;
    end
  end

  // The latched copy keeps the bus request alive if the requester withdraws.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_strb   <= '0;
      lat_wr     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (gnt_ifu || !ifu_arvalid)                starve_cnt <= '0;
        else if ((gnt_ld || gnt_st) && !starve_full) starve_cnt <= starve_cnt + 1'b1;
      end
      if (gnt_ifu) begin
        lat_addr  <= ifu_araddr;
        lat_strb  <= 8'h0f;
        lat_wdata <= '0;
        lat_wr    <= 1'b0;
      end else if (gnt_ld) begin
        lat_addr  <= lsu_araddr;
        lat_strb  <= lsu_rstrb;
        lat_wdata <= '0;
        lat_wr    <= 1'b0;
      end else if (gnt_st) begin
        lat_addr  <= lsu_awaddr;
        lat_strb  <= lsu_wstrb;
        lat_wdata <= lsu_wdata;
        lat_wr    <= 1'b1;
      end
    end
  end

`ifdef YSYX_MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_cnt;

  // Counts cycles of the current grant; fires on the TIMEOUT-th one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              wd_cnt <= '0;
    else if (state == IDLE)  wd_cnt <= '0;
    else                     wd_cnt <= wd_cnt + 8'd1;
  end

  assign wd_hit = (state != IDLE) && (wd_cnt == WD_LAST);
`else
  // Watchdog absent: never fires, so out_bus_err stays 0.
  assign wd_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_nx        = state;
    out_ifu_rdata   = '0;
    out_ifu_rvalid  = 1'b0;
    out_lsu_rdata   = '0;
    out_lsu_rvalid  = 1'b0;
    out_lsu_wready  = 1'b0;
    out_bus_araddr  = '0;
    out_bus_arvalid = 1'b0;
    out_bus_rstrb   = '0;
    out_bus_awaddr  = '0;
    out_bus_awvalid = 1'b0;
    out_bus_wdata   = '0;
    out_bus_wstrb   = '0;
    out_bus_wvalid  = 1'b0;
    out_bus_err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_ifu)     state_nx = G_IFU;
        else if (gnt_st) state_nx = G_ST;
        else if (gnt_ld) state_nx = G_LD;
      end
      G_IFU: begin
        out_bus_arvalid = 1'b1;
        out_bus_araddr  = ifu_arvalid ? ifu_araddr : lat_addr;
        out_bus_rstrb   = 8'h0f;
        if (bus_rvalid) begin
          state_nx       = IDLE;
          out_ifu_rvalid = ifu_arvalid;
          out_ifu_rdata  = ifu_arvalid ? bus_rdata : '0;
        end else if (wd_hit) begin
          state_nx       = IDLE;
          out_bus_err    = 1'b1;
          out_ifu_rvalid = ifu_arvalid;
        end else if (!ifu_arvalid) begin
          state_nx = DRAIN;
        end
      end
      G_LD: begin
        out_bus_arvalid = 1'b1;
        out_bus_araddr  = lsu_arvalid ? lsu_araddr : lat_addr;
        out_bus_rstrb   = lsu_arvalid ? lsu_rstrb : lat_strb;
        if (bus_rvalid) begin
          state_nx       = IDLE;
          out_lsu_rvalid = lsu_arvalid;
          out_lsu_rdata  = lsu_arvalid ? bus_rdata : '0;
        end else if (wd_hit) begin
          state_nx       = IDLE;
          out_bus_err    = 1'b1;
          out_lsu_rvalid = lsu_arvalid;
        end else if (!lsu_arvalid) begin
          state_nx = DRAIN;
        end
      end
      G_ST: begin
        out_bus_awvalid = 1'b1;
        out_bus_wvalid  = 1'b1;
        out_bus_awaddr  = lsu_awvalid ? lsu_awaddr : lat_addr;
        out_bus_wdata   = lsu_awvalid ? lsu_wdata : lat_wdata;
        out_bus_wstrb   = lsu_awvalid ? lsu_wstrb : lat_strb;
        if (bus_wready) begin
          state_nx       = IDLE;
          out_lsu_wready = lsu_awvalid;
        end else if (wd_hit) begin
          state_nx       = IDLE;
          out_bus_err    = 1'b1;
          out_lsu_wready = lsu_awvalid;
        end else if (!lsu_awvalid) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // Response is swallowed: the requester has already walked away.
        if (lat_wr) begin
          out_bus_awvalid = 1'b1;
          out_bus_wvalid  = 1'b1;
          out_bus_awaddr  = lat_addr;
          out_bus_wdata   = lat_wdata;
          out_bus_wstrb   = lat_strb;
          if (bus_wready) state_nx = IDLE;
        end else begin
          out_bus_arvalid = 1'b1;
          out_bus_araddr  = lat_addr;
          out_bus_rstrb   = lat_strb;
          if (bus_rvalid) state_nx = IDLE;
        end
        if (state_nx == DRAIN && wd_hit) begin
          state_nx    = IDLE;
          out_bus_err = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_busy = (state != IDLE);

endmodule

// File: tb/tb_ysyx_mem_arb.sv
// Scoreboard bench for ysyx_mem_arb: requester/bus models feed queues, monitors pop and compare.
module tb_ysyx_mem_arb;
  localparam int XLEN = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [XLEN-1:0] ifu_araddr = '0, lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0;
  logic            ifu_arvalid = 1'b0, lsu_arvalid = 1'b0, lsu_awvalid = 1'b0;
  logic [7:0]      lsu_rstrb = '0, lsu_wstrb = '0;
  logic [XLEN-1:0] bus_rdata = '0;
  logic            bus_rvalid = 1'b0, bus_wready = 1'b0;

  logic [XLEN-1:0] out_ifu_rdata, out_lsu_rdata, out_bus_araddr, out_bus_awaddr, out_bus_wdata;
  logic            out_ifu_rvalid, out_lsu_rvalid, out_lsu_wready, out_bus_arvalid;
  logic            out_bus_awvalid, out_bus_wvalid, out_bus_err, out_busy;
  logic [7:0]      out_bus_rstrb, out_bus_wstrb;

  ysyx_mem_arb #(.XLEN(XLEN), .STARVE_MAX(4), .TIMEOUT(255)) dut (
    .clock(clock), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
    .out_ifu_rdata(out_ifu_rdata), .out_ifu_rvalid(out_ifu_rvalid),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
    .out_lsu_rdata(out_lsu_rdata), .out_lsu_rvalid(out_lsu_rvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .out_lsu_wready(out_lsu_wready),
    .out_bus_araddr(out_bus_araddr), .out_bus_arvalid(out_bus_arvalid),
    .out_bus_rstrb(out_bus_rstrb), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .out_bus_awaddr(out_bus_awaddr), .out_bus_awvalid(out_bus_awvalid),
    .out_bus_wdata(out_bus_wdata), .out_bus_wstrb(out_bus_wstrb),
    .out_bus_wvalid(out_bus_wvalid), .bus_wready(bus_wready),
    .out_bus_err(out_bus_err), .out_busy(out_busy)
  );

  logic [183:0] all_outs;
  assign all_outs = {out_ifu_rdata, out_lsu_rdata, out_bus_araddr, out_bus_awaddr, out_bus_wdata,
                     out_ifu_rvalid, out_lsu_rvalid, out_lsu_wready, out_bus_arvalid,
                     out_bus_awvalid, out_bus_wvalid, out_bus_err, out_busy,
                     out_bus_rstrb, out_bus_wstrb};

  typedef struct packed {logic [1:0] kind; logic [31:0] data;} rsp_t;  // 0 ifu, 1 load, 2 store
  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data; logic [7:0] strb;} bus_t;
  typedef struct packed {logic [31:0] addr; logic [7:0] strb; logic wd;} ld_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [7:0] strb;} st_t;

  rsp_t        exp_q[$];
  bus_t        bus_q[$];
  logic [31:0] ifu_q[$];
  ld_t         ld_q[$];
  st_t         st_q[$];

  int n_cmp = 0, n_bad = 0;
  bit abort = 1'b0, bus_hold = 1'b0, inject_late = 1'b0;
  int bus_lat = 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'ha5a5_0000);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input int k);
    int n = 0;
    bit got = 1'b0;
    while (!got && !abort && n < 300) begin
      @(negedge clock);
      n++;
      got = (k == 0) ? out_ifu_rvalid : (k == 1) ? out_lsu_rvalid : out_lsu_wready;
    end
    if (!got && !abort) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout_%0d: no response after %0d cycles, expected one", k, n);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (2) @(negedge clock);
    while ((ifu_q.size() + ld_q.size() + st_q.size() + exp_q.size() + bus_q.size() != 0 ||
            out_busy || ifu_arvalid || lsu_arvalid || lsu_awvalid) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_idle: still busy after %0d cycles, expected idle", name, n);
    end
  endtask

  // IFU requester: holds valid until its response, then moves to the next queued fetch.
  initial forever begin
    if (ifu_q.size() == 0 || abort) begin
      ifu_arvalid = 1'b0;
      @(posedge clock); #1;
    end else begin
      ifu_araddr  = ifu_q.pop_front();
      ifu_arvalid = 1'b1;
      wait_rsp(0);
      @(posedge clock); #1;
    end
  end

  initial forever begin : ld_req
    ld_t r;
    if (ld_q.size() == 0 || abort) begin
      lsu_arvalid = 1'b0;
      @(posedge clock); #1;
    end else begin
      r = ld_q.pop_front();
      lsu_araddr  = r.addr;
      lsu_rstrb   = r.strb;
      lsu_arvalid = 1'b1;
      if (r.wd) begin
        @(posedge clock); #1;
        lsu_arvalid = 1'b0;
        lsu_araddr  = '0;
        lsu_rstrb   = '0;
      end else begin
        wait_rsp(1);
        @(posedge clock); #1;
      end
    end
  end

  initial forever begin : st_req
    st_t s;
    if (st_q.size() == 0 || abort) begin
      lsu_awvalid = 1'b0;
      @(posedge clock); #1;
    end else begin
      s = st_q.pop_front();
      lsu_awaddr  = s.addr;
      lsu_wdata   = s.data;
      lsu_wstrb   = s.strb;
      lsu_awvalid = 1'b1;
      wait_rsp(2);
      @(posedge clock); #1;
    end
  end

  // Bus slave: checks each new request against bus_q, answers after bus_lat request cycles.
  initial begin : bus_model
    int   age;
    bus_t b;
    age = 0;
    forever begin
      @(posedge clock); #2;
      if (bus_rvalid || bus_wready) begin
        bus_rvalid = 1'b0;
        bus_wready = 1'b0;
        bus_rdata  = '0;
        age        = 0;
      end else if (inject_late) begin
        inject_late = 1'b0;
        bus_rvalid  = 1'b1;
        bus_wready  = 1'b1;
        bus_rdata   = 32'hcafe_f00d;
      end else if (out_bus_arvalid || out_bus_awvalid) begin
        age++;
        if (age == 1) begin
          if (bus_q.size() == 0) begin
            check("bus_unexpected", {out_bus_arvalid, out_bus_awvalid}, 0);
          end else begin
            b = bus_q.pop_front();
            if (b.wr) begin
              check("bus_wr_addr", {out_bus_awvalid, out_bus_wvalid, out_bus_awaddr}, {2'b11, b.addr});
              check("bus_wr_data", {out_bus_wstrb, out_bus_wdata}, {b.strb, b.data});
            end else begin
              check("bus_rd", {out_bus_arvalid, out_bus_rstrb, out_bus_araddr}, {1'b1, b.strb, b.addr});
            end
          end
        end
        if (!bus_hold && age >= bus_lat) begin
          if (out_bus_awvalid) bus_wready = 1'b1;
          else begin
            bus_rvalid = 1'b1;
            bus_rdata  = mem_rd(out_bus_araddr);
          end
        end
      end else begin
        age = 0;
      end
    end
  end

  // Response monitor
  rsp_t e;
  int   np;
  always @(negedge clock) begin
    np = int'(out_ifu_rvalid) + int'(out_lsu_rvalid) + int'(out_lsu_wready);
    if (np > 1) check("multi_rsp", 64'(np), 1);
    else if (np == 1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {out_ifu_rvalid, out_lsu_rvalid, out_lsu_wready}, 0);
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          2'd0:    check("ifu_rsp", {out_ifu_rvalid, out_ifu_rdata}, {1'b1, e.data});
          2'd1:    check("ld_rsp", {out_lsu_rvalid, out_lsu_rdata}, {1'b1, e.data});
          default: check("st_rsp", {out_lsu_wready, out_lsu_rvalid}, 2'b10);
        endcase
      end
    end
  end

  initial begin : main
    int n, held;
    repeat (3) @(negedge clock);
    check("reset_outs", 64'($countones(all_outs)), 0);
    reset = 1'b1;
    @(negedge clock);

    // IFU alone, bus answers on the second request cycle
    bus_lat = 2;
    ifu_q.push_back(32'h8000_0000);
    bus_q.push_back('{1'b0, 32'h8000_0000, 32'h0, 8'h0f});
    exp_q.push_back('{2'd0, 32'h0000_0413});
    wait_idle("t1");
    bus_lat = 1;

    // IFU and load together: load first
    ifu_q.push_back(32'h8000_0004);
    ld_q.push_back('{32'h0f00_0040, 8'h03, 1'b0});
    bus_q.push_back('{1'b0, 32'h0f00_0040, 32'h0, 8'h03});
    bus_q.push_back('{1'b0, 32'h8000_0004, 32'h0, 8'h0f});
    exp_q.push_back('{2'd1, 32'haaa5_0040});
    exp_q.push_back('{2'd0, 32'h25a5_0004});
    wait_idle("t2");

    // Store beats load
    st_q.push_back('{32'h0f00_0010, 32'hdead_beef, 8'h0f});
    ld_q.push_back('{32'h0f00_0020, 8'h0f, 1'b0});
    bus_q.push_back('{1'b1, 32'h0f00_0010, 32'hdead_beef, 8'h0f});
    bus_q.push_back('{1'b0, 32'h0f00_0020, 32'h0, 8'h0f});
    exp_q.push_back('{2'd2, 32'h0});
    exp_q.push_back('{2'd1, 32'haaa5_0020});
    wait_idle("t3");

    // Starvation bound: 4 loads, forced fetch, counter restarts, 2 loads, fetch
    ifu_q.push_back(32'h8000_0010);
    ifu_q.push_back(32'h8000_0014);
    for (int i = 0; i < 6; i++) ld_q.push_back('{32'h0f00_0100 + 32'(4*i), 8'hff, 1'b0});
    for (int i = 0; i < 4; i++) begin
      bus_q.push_back('{1'b0, 32'h0f00_0100 + 32'(4*i), 32'h0, 8'hff});
      exp_q.push_back('{2'd1, 32'haaa5_0100 + 32'(4*i)});
    end
    bus_q.push_back('{1'b0, 32'h8000_0010, 32'h0, 8'h0f});
    exp_q.push_back('{2'd0, 32'h25a5_0010});
    bus_q.push_back('{1'b0, 32'h0f00_0110, 32'h0, 8'hff});
    exp_q.push_back('{2'd1, 32'haaa5_0110});
    bus_q.push_back('{1'b0, 32'h0f00_0114, 32'h0, 8'hff});
    exp_q.push_back('{2'd1, 32'haaa5_0114});
    bus_q.push_back('{1'b0, 32'h8000_0014, 32'h0, 8'h0f});
    exp_q.push_back('{2'd0, 32'h25a5_0014});
    wait_idle("t4");

    // Load withdrawn in G_LD: request held from latch, response swallowed
    bus_lat = 3;
    ld_q.push_back('{32'h0f00_0200, 8'hff, 1'b1});
    bus_q.push_back('{1'b0, 32'h0f00_0200, 32'h0, 8'hff});
    held = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (out_bus_arvalid && !lsu_arvalid) held++;
    end
    check("wd_held_cycles", 64'(held), 3);
    wait_idle("t5");
    check("wd_idle", {out_busy, out_lsu_rvalid}, 0);
    bus_lat = 1;

    // Reset mid-G_ST with a silent bus
    bus_hold = 1'b1;
    st_q.push_back('{32'h0f00_0300, 32'h1234_5678, 8'hf0});
    bus_q.push_back('{1'b1, 32'h0f00_0300, 32'h1234_5678, 8'hf0});
    n = 0;
    do begin @(negedge clock); n++; end while (!out_busy && n < 20);
    check("st_granted", {out_bus_awvalid, out_bus_wvalid, out_busy}, 3'b111);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("reset_mid_outs", 64'($countones(all_outs)), 0);
    abort = 1'b1;
    repeat (3) @(negedge clock);
    reset    = 1'b1;
    abort    = 1'b0;
    bus_hold = 1'b0;
    @(negedge clock);
    check("post_reset_idle", {out_busy, out_bus_awvalid, out_bus_arvalid}, 0);
    inject_late = 1'b1;
    @(negedge clock);
    check("late_rsp_ignored", {out_ifu_rvalid, out_lsu_rvalid, out_lsu_wready, out_busy}, 0);
    @(negedge clock);
    check("late_rsp_idle", {out_busy, out_bus_err}, 0);

    check("exp_q_left", 64'(exp_q.size()), 0);
    check("bus_q_left", 64'(bus_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
